// File: rtl/oneshot_repeat.sv
// Turns a debounced button level into single-cycle command pulses with
// keyboard-style auto-repeat while held, plus a running pulse count.
module oneshot_repeat #(
  parameter int HOLD_TICKS = 50,
  parameter int RATE_TICKS = 10,
  parameter int CW         = 8,
  parameter int PW         = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          din,
  input  logic          en,
  output logic          pulse,
  output logic          held,
  output logic          repeating,
  output logic [PW-1:0] pcount
);

  typedef enum logic [1:0] {LOCK, IDLE, DELAY, REPEAT} state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(RATE_TICKS - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LOCK;
      cnt       <= '0;
      pulse     <= 1'b0;
      held      <= 1'b0;
      repeating <= 1'b0;
      pcount    <= '0;
    end else begin
      pulse <= 1'b0;
      if (!en) begin
        state     <= LOCK;
        cnt       <= '0;
        held      <= 1'b0;
        repeating <= 1'b0;
      end else begin
        case (state)
          LOCK: begin
            if (!din) state <= IDLE;
          end
          IDLE: begin
            if (din) begin
              state  <= DELAY;
              cnt    <= '0;
              held   <= 1'b1;
              pulse  <= 1'b1;
              pcount <= pcount + 1'b1;
            end
          end
          DELAY: begin
            if (!din) begin
              state <= IDLE;
              cnt   <= '0;
              held  <= 1'b0;
            end else if (tick) begin
              if (cnt != HOLD_LAST) begin
                cnt <= cnt + 1'b1;
              end else if (!pulse) begin
                // A terminal tick landing on a pulse cycle is held over to the
                // next tick so pulses always stay at least two cycles apart.
                state     <= REPEAT;
                cnt       <= '0;
                repeating <= 1'b1;
                pulse     <= 1'b1;
                pcount    <= pcount + 1'b1;
              end
            end
          end
          REPEAT: begin
            if (!din) begin
              state     <= IDLE;
              cnt       <= '0;
              held      <= 1'b0;
              repeating <= 1'b0;
            end else if (tick) begin
              if (cnt != RATE_LAST) begin
                cnt <= cnt + 1'b1;
              end else if (!pulse) begin
                cnt    <= '0;
                pulse  <= 1'b1;
                pcount <= pcount + 1'b1;
              end
            end
          end
          default: begin
            state <= LOCK;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oneshot_repeat.sv
// Bench for oneshot_repeat: expected pulses (edge, repeating, pcount) are
// queued as stimulus is driven and retired by a monitor on the falling edge.
module tb_oneshot_repeat;

  localparam int HOLD = 3;
  localparam int RATE = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       din = 1'b0;
  logic       en = 1'b1;
  logic       pulse, held, repeating;
  logic [7:0] pcount;

  int         cyc = 0;
  int         nvec = 0;
  int         nerr = 0;
  logic [7:0] exp_pc = 8'd0;
  logic       prev_pulse = 1'b0;

  typedef struct {
    int         cyc;
    logic       rep;
    logic [7:0] pc;
  } exp_t;
  exp_t sb[$];

  oneshot_repeat #(.HOLD_TICKS(HOLD), .RATE_TICKS(RATE), .CW(8), .PW(8)) dut (
    .clk(clk), .reset(reset), .tick(tick), .din(din), .en(en),
    .pulse(pulse), .held(held), .repeating(repeating), .pcount(pcount)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every pulse must match the head of the queue.
  always @(negedge clk) begin
    if (pulse === 1'b1) begin
      chk("pulse_gap", {31'd0, prev_pulse}, 0);
      chk("held_on_pulse", {31'd0, held}, 1);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_edge", cyc, e.cyc);
        chk("pulse_rep", {31'd0, repeating}, {31'd0, e.rep});
        chk("pulse_pcount", {24'd0, pcount}, {24'd0, e.pc});
      end
    end
    prev_pulse = pulse;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      tick = ((cyc + 1) % 4 == 0);
    end
  endtask

  task automatic wait_to(input int x);
    while (cyc < x) step();
  endtask

  task automatic push(input int c, input logic rep);
    exp_t e;
    exp_pc = exp_pc + 8'd1;
    e.cyc = c;
    e.rep = rep;
    e.pc  = exp_pc;
    sb.push_back(e);
  endtask

  // Tick t of a hold pressed at edge e is sampled at edge e+4t-1.
  task automatic sched(input int e, input int nticks);
    push(e, 1'b0);
    for (int t = 1; t <= nticks; t++)
      if (t == HOLD || (t > HOLD && (t - HOLD) % RATE == 0)) push(e + 4 * t - 1, 1'b1);
  endtask

  task automatic next_press(output int e);
    e = cyc + 1;
    while (e % 4 != 1) e++;
  endtask

  task automatic press_for(input int nticks);
    int e;
    int r;
    next_press(e);
    wait_to(e - 1);
    din = 1'b1;
    sched(e, nticks);
    r = e + 4 * nticks;
    wait_to(r - 1);
    chk("held_before_release", {31'd0, held}, 1);
    din = 1'b0;
    step();
    chk("held_after_release", {31'd0, held}, 0);
    chk("rep_after_release", {31'd0, repeating}, 0);
  endtask

  initial begin
    int e;
    // Held through reset
    din = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_pulse", {31'd0, pulse}, 0);
    chk("rst_held", {31'd0, held}, 0);
    chk("rst_rep", {31'd0, repeating}, 0);
    chk("rst_pcount", {24'd0, pcount}, 0);
    step(3);
    reset = 1'b1;
    step(20);
    chk("lock_pcount", {24'd0, pcount}, 0);
    chk("lock_held", {31'd0, held}, 0);
    din = 1'b0;
    step(3);
    press_for(1);
    step(6);
    chk("lock_sb_drain", sb.size(), 0);
    chk("lock_final_pcount", {24'd0, pcount}, {24'd0, exp_pc});

    // Short press of two ticks
    press_for(2);
    step(6);
    chk("short_sb_drain", sb.size(), 0);
    chk("short_pcount", {24'd0, pcount}, {24'd0, exp_pc});

    // Long hold of nine ticks: pulses at press and ticks 3,5,7,9
    press_for(9);
    step(6);
    chk("long_sb_drain", sb.size(), 0);
    chk("long_pcount", {24'd0, pcount}, 8'd7);

    // Release coincident with the terminal tick in DELAY
    next_press(e);
    wait_to(e - 1);
    din = 1'b1;
    push(e, 1'b0);
    wait_to(e + 10);
    din = 1'b0;
    step();
    chk("term_held", {31'd0, held}, 0);
    step(20);
    chk("term_pcount", {24'd0, pcount}, {24'd0, exp_pc});
    press_for(1);
    step(6);
    chk("term_sb_drain", sb.size(), 0);

    // Disable mid-repeat with din still high
    next_press(e);
    wait_to(e - 1);
    din = 1'b1;
    sched(e, HOLD);
    wait_to(e + 12);
    chk("dis_rep_before", {31'd0, repeating}, 1);
    en = 1'b0;
    step();
    chk("dis_held", {31'd0, held}, 0);
    chk("dis_rep", {31'd0, repeating}, 0);
    step(12);
    chk("dis_held_later", {31'd0, held}, 0);
    en = 1'b1;
    step(20);
    chk("reen_held", {31'd0, held}, 0);
    chk("reen_pcount", {24'd0, pcount}, {24'd0, exp_pc});
    din = 1'b0;
    step(3);
    press_for(1);
    step(6);
    chk("dis_sb_drain", sb.size(), 0);

    // Asynchronous reset mid-repeat, then wrap of the pulse count
    next_press(e);
    wait_to(e - 1);
    din = 1'b1;
    push(e, 1'b0);
    wait_to(e + 11);
    chk("mid_pulse_pre", {31'd0, pulse}, 1);
    chk("mid_rep_pre", {31'd0, repeating}, 1);
    reset = 1'b0;
    din = 1'b0;
    #1;
    chk("arst_pulse", {31'd0, pulse}, 0);
    chk("arst_held", {31'd0, held}, 0);
    chk("arst_rep", {31'd0, repeating}, 0);
    chk("arst_pcount", {24'd0, pcount}, 0);
    exp_pc = 8'd0;
    #2 reset = 1'b1;
    step(4);
    chk("arst_sb_drain", sb.size(), 0);
    for (int i = 0; i < 257; i++) press_for(1);
    step(6);
    chk("wrap_pcount", {24'd0, pcount}, 1);
    chk("wrap_sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/oneshot_repeat.md
# oneshot_repeat

Converts the level output of the push-button debouncer into single-cycle command pulses, with keyboard-style auto-repeat while the button stays held. It sits directly downstream of the debouncer and shares the debouncer's `tick` timebase strobe. Its pulses drive the register/step controls of the emulated PicoBlaze front panel. A running pulse count is provided for LED display and for verification.

## Interface
- `HOLD_TICKS`, default 50: ticks of continuous hold after the initial pulse before auto-repeat begins; legal range 1..2^CW-1.
- `RATE_TICKS`, default 10: ticks between successive repeat pulses; legal range 1..2^CW-1.
- `CW`, default 8: width of the internal tick counter.
- `PW`, default 8: width of `pcount`.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0); one clock, no other clock domains.
- `tick` in 1: single-cycle timebase strobe, the same one used by the debouncer.
- `din` in 1: debounced button level from the debouncer, already synchronous to `clk`.
- `en` in 1: enable; when 0, pulse generation is suppressed.
- `pulse` out 1: single-cycle command pulse; registered.
- `held` out 1: 1 while the FSM is in DELAY or REPEAT; registered.
- `repeating` out 1: 1 while the FSM is in REPEAT; registered.
- `pcount` out PW: number of pulses issued, modulo 2^PW; registered.

## Operation
- **FSM states:** LOCK, IDLE, DELAY, REPEAT, plus counter `cnt[CW-1:0]`.
- **Reset** (`reset`=0, asynchronous):
  - state=LOCK, cnt=0.
  - pulse=0, held=0, repeating=0, pcount=0.
- **LOCK** (waits for a release, so a button held through reset or disable never fires):
  - if `en`=1 and `din`=0, go to IDLE.
  - otherwise stay in LOCK.
- **IDLE:**
  - if `en`=1 and `din`=1, go to DELAY with cnt=0 and issue a pulse.
- **DELAY:**
  - if `din`=0, go to IDLE.
  - else if `tick`=1 and cnt==HOLD_TICKS-1, go to REPEAT with cnt=0 and issue a pulse.
  - else if `tick`=1, cnt=cnt+1.
- **REPEAT:**
  - if `din`=0, go to IDLE.
  - else if `tick`=1 and cnt==RATE_TICKS-1, stay in REPEAT with cnt=0 and issue a pulse.
  - else if `tick`=1, cnt=cnt+1.
- **Disable:** `en`=0 in any state moves the FSM to LOCK on the next edge.
  - Takes priority over every other transition.
  - No pulse is issued on that edge.
  - cnt is cleared.
- **Issuing a pulse** means `pulse`=1 for exactly the next cycle and pcount=pcount+1.
- **pcount wrap:** pcount wraps from 2^PW-1 to 0 with no flag.
- **Release priority:** `din`=0 in the same cycle as a terminal-count tick returns the FSM to IDLE with no pulse.
- **cnt range:** cnt never exceeds max(HOLD_TICKS, RATE_TICKS)-1 and never wraps.
- **`tick` outside DELAY/REPEAT** is ignored.

## Timing
- **Press latency:** if `din` is sampled 1 in IDLE at edge k, then `pulse`=1 and `held`=1 during cycle k to k+1, and `pulse`=0 after edge k+1.
- **First repeat:** the first repeat pulse follows the HOLD_TICKS-th tick seen in DELAY, one cycle after the edge that samples that tick.
- **Repeat spacing:** subsequent repeat pulses follow every RATE_TICKS-th tick.
- **`repeating`** rises in the same cycle as the first repeat pulse.
- **Release:** `held` and `repeating` fall one cycle after the edge that samples `din`=0.
- **Minimum pulse spacing** is 2 cycles. `pulse` is never high on two consecutive cycles.
- **Asynchronous reset:** assertion clears all outputs immediately, without waiting for a clock edge. Release is assumed synchronised externally; the first state evaluation is the first edge after release.
- **Reset mid-repeat:** `pulse` drops immediately and pcount=0.

## Test plan
All scenarios use HOLD_TICKS=3, RATE_TICKS=2, PW=8, with `tick` every 4th clk.

- **Held through reset:** `din`=1 held through reset release, then released, then pressed → no pulse until the new press; then exactly 1 pulse and pcount=1.
- **Short press:** press for 2 ticks, then release → exactly 1 pulse, `repeating` never 1, `held` falls 1 cycle after release, pcount=1.
- **Long hold:** hold for 9 ticks → pulses at press, after tick 3, tick 5, tick 7 and tick 9; pcount=5; `repeating`=1 from the second pulse onward.
- **Release at terminal tick:** release in the same cycle as tick 3 in DELAY → no second pulse, state IDLE, pcount=1.
- **Disable mid-repeat:** drop `en`=0 during REPEAT while `din` stays 1, then raise `en`=1 again → no pulses and `held`=0 while disabled; no pulse after re-enable until `din` goes 0 and then 1 again.
- **Reset and wrap:** assert reset mid-REPEAT → outputs 0 with no clock edge. Then issue 257 short presses → pcount=1 (wrap confirmed).
